// File: rtl/freq_mult_pkg.sv
// Shared types and defaults for the frequency-multiplier datapath.
// Measurement state encodings and default counter width.
package freq_mult_pkg;

  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    M_IDLE  = 2'd0,
    M_ARM   = 2'd1,
    M_COUNT = 2'd2,
    M_DONE  = 2'd3
  } m_state_e;

endpackage

// File: rtl/freq_mult_datapath_if.sv
// Control/status bundle between multiplier controller and datapath.
// The controller is master; the datapath is slave.
interface freq_mult_datapath_if #(
  parameter int CNT_W = 16
);

  logic             init_ratio;
  logic             shift;
  logic             preload_clk_divider;
  logic             completed;
  logic             overflow;
  logic [CNT_W-1:0] ratio;

  modport master (
    output init_ratio,
    output shift,
    output preload_clk_divider,
    input  completed,
    input  overflow,
    input  ratio
  );

  modport slave (
    input  init_ratio,
    input  shift,
    input  preload_clk_divider,
    output completed,
    output overflow,
    output ratio
  );

endinterface

// File: rtl/clk_toggle_divider.sv
// Programmable toggle divider: OutClk period is 2*ratio_active cycles.
// Reloads only on a 0->1 transition of the preload level.
module clk_toggle_divider #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_preload,
  input  logic [CNT_W-1:0] i_ratio,
  output logic             o_clk
);

  logic             r_pre_d;
  logic             r_en;
  logic             r_out;
  logic [CNT_W-1:0] r_ratio_act;
  logic [CNT_W-1:0] r_div_cnt;
  logic             w_load;

  assign w_load = i_preload & ~r_pre_d;
  assign o_clk  = r_out;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pre_d     <= 1'b0;
      r_en        <= 1'b0;
      r_out       <= 1'b0;
      r_ratio_act <= '0;
      r_div_cnt   <= '0;
    end else begin
      r_pre_d <= i_preload;
      // A load edge takes priority over the terminal count.
      if (w_load) begin
        if (i_ratio != '0) begin
          r_ratio_act <= i_ratio;
          r_div_cnt   <= i_ratio - CNT_W'(1);
          r_en        <= 1'b1;
        end else begin
          r_en  <= 1'b0;
          r_out <= 1'b0;
        end
      end else if (r_en) begin
        if (r_div_cnt == '0) begin
          r_out     <= ~r_out;
          r_div_cnt <= r_ratio_act - CNT_W'(1);
        end else begin
          r_div_cnt <= r_div_cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/freq_mult_datapath.sv
// Measures InClk period in RefClk cycles, scales it by shift pulses
// and drives a toggle divider to produce OutClk.
module freq_mult_datapath
  import freq_mult_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 RefClk,
  input  logic                 rst,
  input  logic                 InClk,
  freq_mult_datapath_if.slave  bus,
  output logic                 OutClk
);

  m_state_e         r_state;
  m_state_e         w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic             r_sync_d;
  logic             w_sync;
  logic             w_rise;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_ratio;
  logic [CNT_W-1:0] w_ratio_nxt;
  logic             r_comp;
  logic             w_comp_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_sync_d;

  assign bus.completed = r_comp;
  assign bus.overflow  = r_ovf;
  assign bus.ratio     = r_ratio;

  always_ff @(posedge RefClk or posedge rst) begin
    if (rst) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], InClk};
      r_sync_d <= w_sync;
    end
  end

  always_ff @(posedge RefClk or posedge rst) begin
    if (rst) begin
      r_state <= M_IDLE;
      r_cnt   <= '0;
      r_ratio <= '0;
      r_comp  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ratio <= w_ratio_nxt;
      r_comp  <= w_comp_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ratio_nxt = r_ratio;
    w_comp_nxt  = r_comp;
    w_ovf_nxt   = r_ovf;
    // init_ratio wins over shift and rise in the same cycle.
    if (bus.init_ratio) begin
      w_state_nxt = M_ARM;
      w_cnt_nxt   = '0;
      w_ratio_nxt = '0;
      w_comp_nxt  = 1'b0;
      w_ovf_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        M_IDLE: ;
        M_ARM: begin
          if (w_rise) begin
            w_state_nxt = M_COUNT;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        M_COUNT: begin
          if (w_rise) begin
            w_ratio_nxt = r_cnt;
            w_comp_nxt  = 1'b1;
            w_state_nxt = M_DONE;
          end else if (r_cnt == '1) begin
            w_ratio_nxt = '1;
            w_ovf_nxt   = 1'b1;
            w_comp_nxt  = 1'b1;
            w_state_nxt = M_DONE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        M_DONE: begin
          if (bus.shift && (r_ratio > CNT_W'(1)))
            w_ratio_nxt = r_ratio >> 1;
        end
        default: w_state_nxt = M_IDLE;
      endcase
    end
  end

  clk_toggle_divider #(
    .CNT_W (CNT_W)
  ) u_div (
    .i_clk     (RefClk),
    .i_rst     (rst),
    .i_preload (bus.preload_clk_divider),
    .i_ratio   (r_ratio),
    .o_clk     (OutClk)
  );

endmodule
